// File: rtl/operand_fetch_pkg.sv
// Shared CPU datapath constants used by the register-read stage, the
// register file and the execute stage.
package operand_fetch_pkg;

  localparam int unsigned CPU_XLEN   = 32;            // data width
  localparam int unsigned CPU_REG_AW = 5;             // register address width
  localparam int unsigned CPU_NREG   = 2**CPU_REG_AW; // architectural registers
  localparam int unsigned CPU_CTRL_W = 16;            // opaque control bundle width

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// op_scoreboard: one pending-write bit per architectural register.
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en/set_addr     an instruction with a destination leaves toward EX
//   clr_en/clr_addr     writeback to clr_addr this cycle
//   pend_en/pend_addr   destination of the instruction currently held in the
//                       output register (not yet issued, not yet in sb)
//   q_addr1..3          lookup addresses
//   busy1..3            hazard flag for each lookup address
module op_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int unsigned REG_AW = CPU_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic              pend_en,
  input  logic [REG_AW-1:0] pend_addr,
  input  logic [REG_AW-1:0] q_addr1,
  input  logic [REG_AW-1:0] q_addr2,
  input  logic [REG_AW-1:0] q_addr3,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3
);

  localparam int unsigned NREG = 2**REG_AW;

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  // A writeback landing this cycle already frees the register (its data is
  // bypassed), and the held-but-unissued instruction counts as pending.
  function automatic logic busy_of(
    input logic [REG_AW-1:0] a,
    input logic [NREG-1:0]   sb,
    input logic              ce,
    input logic [REG_AW-1:0] ca,
    input logic              pe,
    input logic [REG_AW-1:0] pa
  );
    return (a != '0) && ((sb[a] && !(ce && ca == a)) || (pe && pa == a));
  endfunction

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    sb_d = sb_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (clr_en && clr_addr == REG_AW'(r)) sb_d[r] = 1'b0;
      if (set_en && set_addr == REG_AW'(r)) sb_d[r] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign busy1 = busy_of(q_addr1, sb_q, clr_en, clr_addr, pend_en, pend_addr);
  assign busy2 = busy_of(q_addr2, sb_q, clr_en, clr_addr, pend_en, pend_addr);
  assign busy3 = busy_of(q_addr3, sb_q, clr_en, clr_addr, pend_en, pend_addr);

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage.
//   in_*        decoded instruction (valid/ready handshake)
//   rf_raddr*   regfile read addresses (combinational copies of in_rs1/in_rs2)
//   rf_rdata*   regfile combinational read data
//   wb_*        writeback port, bypassed into operands and used to clear
//               pending-write bits
//   flush       squash held and incoming instruction
//   out_*       registered operands/control toward EX (valid/ready)
// Stalls on RAW/WAW against pending writes; one-cycle latency, full throughput.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN   = CPU_XLEN,
  parameter int unsigned REG_AW = CPU_REG_AW,
  parameter int unsigned CTRL_W = CPU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [XLEN-1:0]   wb_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic busy_rs1, busy_rs2, busy_rd;
  logic hazard;
  logic accept;
  logic out_fire;
  logic [XLEN-1:0] op1_sel, op2_sel;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  assign out_fire = out_valid && out_ready;

  op_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (out_fire && out_rd_we),
    .set_addr  (out_rd),
    .clr_en    (wb_we),
    .clr_addr  (wb_waddr),
    .pend_en   (out_valid && out_rd_we),
    .pend_addr (out_rd),
    .q_addr1   (in_rs1),
    .q_addr2   (in_rs2),
    .q_addr3   (in_rd),
    .busy1     (busy_rs1),
    .busy2     (busy_rs2),
    .busy3     (busy_rd)
  );

  assign hazard = (in_use_rs1 && busy_rs1) || (in_use_rs2 && busy_rs2) ||
                  (in_rd_we && busy_rd);
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // The regfile commits wb data only at the edge, so a same-cycle write must
  // be forwarded here; x0 always reads zero.
  always_comb begin
    op1_sel = rf_rdata1;
    if (in_rs1 == '0)                        op1_sel = '0;
    else if (wb_we && wb_waddr == in_rs1)    op1_sel = wb_wdata;
    op2_sel = rf_rdata2;
    if (in_rs2 == '0)                        op2_sel = '0;
    else if (wb_we && wb_waddr == in_rs2)    op2_sel = wb_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
      out_pc    <= '0;
      out_imm   <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= op1_sel;
      out_op2   <= op2_sel;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
      out_pc    <= in_pc;
      out_imm   <= in_imm;
      out_ctrl  <= in_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [15:0] ctrl;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rd_we;
  logic [31:0] in_pc, in_imm;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2, out_pc, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [15:0] out_ctrl;

  logic [31:0] rf [32];
  exp_t        exp_q[$];
  int          checks;
  int          errors;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  operand_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_use_rs1 (in_use_rs1),
    .in_use_rs2 (in_use_rs2),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .in_pc      (in_pc),
    .in_imm     (in_imm),
    .in_ctrl    (in_ctrl),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_rd     (out_rd),
    .out_rd_we  (out_rd_we),
    .out_pc     (out_pc),
    .out_imm    (out_imm),
    .out_ctrl   (out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Wait past the next rising edge; a one-cycle writeback is retired into
  // the regfile model here and deasserted.
  task automatic tick;
    @(posedge clk);
    #1;
    if (wb_we) begin
      rf[wb_waddr] = wb_wdata;
      wb_we = 1'b0;
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic we,
                        input logic [31:0] pc);
    in_rs1 = rs1; in_use_rs1 = u1;
    in_rs2 = rs2; in_use_rs2 = u2;
    in_rd = rd; in_rd_we = we;
    in_pc = pc; in_imm = pc + 32'h8; in_ctrl = pc[15:0];
  endtask

  task automatic push(input logic [31:0] op1, input logic [31:0] op2, input logic [4:0] rd,
                      input logic we, input logic [31:0] pc);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.rd = rd; e.rd_we = we;
    e.pc = pc; e.imm = pc + 32'h8; e.ctrl = pc[15:0];
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic monitor;
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got = '{out_op1, out_op2, out_rd, out_rd_we, out_pc, out_imm, out_ctrl};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h required no output", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL out_pc%h: got %h required %h", e.pc, got, e);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[0] = 32'h0000_1234;
    rf[5] = 32'h0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    fork monitor(); join_none

    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sb", 64'(dut.u_sb.sb_q), 64'd0);
    chk("rst_out_op1", 64'(out_op1), 64'd0);
    rst_n = 1'b1;
    tick();

    // Bypass: rs1=5 from same-cycle writeback, rs2=x0 forced zero
    set_in(5, 1, 0, 1, 9, 1, 32'h100);
    in_valid = 1'b1;
    wb(5, 32'hDEADBEEF);
    @(negedge clk);
    chk("byp_ready", 64'(in_ready), 64'd1);
    push(32'hDEADBEEF, 32'h0, 9, 1, 32'h100);
    tick();
    in_valid = 1'b0;
    tick();
    chk("byp_sb_set9", 64'(dut.u_sb.sb_q), 64'h200);
    wb(9, 32'h99);
    tick();
    chk("byp_sb_clr9", 64'(dut.u_sb.sb_q), 64'd0);

    // RAW on r3
    set_in(1, 1, 2, 1, 3, 1, 32'h200);
    in_valid = 1'b1;
    @(negedge clk);
    chk("raw_first_ready", 64'(in_ready), 64'd1);
    push(32'h1000_0001, 32'h1000_0002, 3, 1, 32'h200);
    tick();
    set_in(3, 1, 0, 0, 10, 1, 32'h300);
    @(negedge clk);
    chk("raw_pend_ready", 64'(in_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("raw_sb_ready", 64'(in_ready), 64'd0);
    chk("raw_sb3", 64'(dut.u_sb.sb_q), 64'h8);
    tick();
    wb(3, 32'hCAFEF00D);
    @(negedge clk);
    chk("raw_release_ready", 64'(in_ready), 64'd1);
    push(32'hCAFEF00D, 32'h0, 10, 1, 32'h300);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("raw_sb3_clr", 64'(dut.u_sb.sb_q), 64'd0);
    tick();
    wb(10, 32'hA);
    tick();
    chk("raw_sb_idle", 64'(dut.u_sb.sb_q), 64'd0);

    // Back-to-back against a held rd=7
    set_in(1, 1, 2, 1, 7, 1, 32'h400);
    in_valid = 1'b1;
    @(negedge clk);
    push(32'h1000_0001, 32'h1000_0002, 7, 1, 32'h400);
    tick();
    set_in(0, 0, 7, 1, 8, 0, 32'h410);
    @(negedge clk);
    chk("b2b_dep_ready", 64'(in_ready), 64'd0);
    #1;
    set_in(1, 1, 2, 1, 11, 1, 32'h420);
    #1;
    chk("b2b_indep_ready", 64'(in_ready), 64'd1);
    push(32'h1000_0001, 32'h1000_0002, 11, 1, 32'h420);
    tick();
    chk("b2b_valid1", 64'(out_valid), 64'd1);
    set_in(2, 1, 1, 1, 12, 0, 32'h430);
    @(negedge clk);
    chk("b2b_third_ready", 64'(in_ready), 64'd1);
    push(32'h1000_0002, 32'h1000_0001, 12, 0, 32'h430);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid2", 64'(out_valid), 64'd1);
    tick();
    chk("b2b_sb", 64'(dut.u_sb.sb_q), 64'h880);
    wb(7, 32'h7);
    tick();
    wb(11, 32'hB);
    tick();
    chk("b2b_sb_clr", 64'(dut.u_sb.sb_q), 64'd0);

    // WAW stall on r4, then set/clear collision
    set_in(0, 0, 0, 0, 4, 1, 32'h500);
    in_valid = 1'b1;
    @(negedge clk);
    push(32'h0, 32'h0, 4, 1, 32'h500);
    tick();
    set_in(0, 0, 0, 0, 4, 1, 32'h510);
    @(negedge clk);
    chk("waw_pend_ready", 64'(in_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("waw_sb_ready", 64'(in_ready), 64'd0);
    wb(4, 32'h44);
    #1;
    chk("waw_release_ready", 64'(in_ready), 64'd1);
    push(32'h0, 32'h0, 4, 1, 32'h510);
    tick();
    in_valid = 1'b0;
    chk("waw_sb_clr", 64'(dut.u_sb.sb_q), 64'd0);
    wb(4, 32'h45);
    tick();
    chk("collide_set_wins", 64'(dut.u_sb.sb_q), 64'h10);
    wb(4, 32'h46);
    tick();
    chk("collide_clr", 64'(dut.u_sb.sb_q), 64'd0);

    // Flush and backpressure with r13 pending
    set_in(0, 0, 0, 0, 13, 1, 32'h600);
    in_valid = 1'b1;
    @(negedge clk);
    push(32'h0, 32'h0, 13, 1, 32'h600);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    set_in(1, 1, 2, 1, 0, 0, 32'h610);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept_ready", 64'(in_ready), 64'd1);
    push(32'h1000_0001, 32'h1000_0002, 0, 0, 32'h610);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_pc", 64'(out_pc), 64'h610);
      chk("bp_op1", 64'(out_op1), 64'h1000_0001);
      tick();
    end
    set_in(1, 1, 2, 1, 0, 0, 32'h620);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 64'(in_ready), 64'd0);
    void'(exp_q.pop_back());
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_sb", 64'(dut.u_sb.sb_q), 64'h2000);

    // Asynchronous reset with a held instruction and a pending bit
    set_in(1, 1, 2, 1, 14, 1, 32'h700);
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst2_accept_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("rst2_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_sb", 64'(dut.u_sb.sb_q), 64'd0);
    chk("rst_async_pc", 64'(out_pc), 64'd0);
    chk("rst_async_rd", 64'(out_rd), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
